gf4_mul_seq: RTL and testbench
==============================

# gf4_mul_seq

Shared, multi-cycle GF(2^4) multiplier for the composite-field S-box datapath. It arbitrates round-robin among NUM_REQ requesters and time-multiplexes one GF(2^2) multiply/scale unit across three phases (high, low, scaled-middle) to form one GF(2^4) product. Area-reduced S-box variants use it in place of three parallel GF(2^2) multipliers.

## Interface
- NUM_REQ, default 2: number of requesters; legal range 2..8.
- ID_W, default $clog2(NUM_REQ): width of the requester-id field.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester operation request.
- req_a  in  4*NUM_REQ  operand A of requester i, in bits [4i+3:4i].
- req_b  in  4*NUM_REQ  operand B of requester i, same packing.
- req_ready  out  NUM_REQ  one-hot acceptance; never more than one bit set.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- out_q  out  4  GF(2^4) product.
- out_id  out  ID_W  index of the requester that owns out_q.
- busy  out  1  high in every state except IDLE.

## Operation
- Basis:
  - GF(2^4) uses normal basis [W^4,W]; bits [3:2] are the high half, [1:0] the low half.
  - Each half is a GF(2^2) element in basis [Ω^2,Ω].
  - The one element is 4'hF; GF(2^2) one is 2'b11.
- mul2(x,y) = {(x1&y1)^e, (x0&y0)^e}, where e = (x1^x0)&(y1^y0).
- scl(x) = {x0, x1^x0} (scale by N).
- Product:
  - ph = mul2(a_hi,b_hi); pl = mul2(a_lo,b_lo).
  - em = scl(mul2(a_hi^a_lo, b_hi^b_lo)).
  - q = {ph^em, pl^em}.
- FSM states: IDLE, PH, PL, MID, DONE.
  - IDLE: if any req_valid is high, grant one requester and go to PH. Grant goes to the first valid index at or after (ptr+1) mod NUM_REQ. In the same cycle, req_ready[grant]=1 and the block latches A, B and the id. ptr updates to the grant index.
  - PH: shared unit computes ph with scaling off; result latched.
  - PL: shared unit computes pl with scaling off; result latched.
  - MID: shared unit computes em with scaling on; out_q and out_id are registered; go to DONE.
  - DONE: out_valid=1. On out_ready=1, go to IDLE.
- req_ready is combinational from the state, ptr and req_valid. It is 0 in every state except IDLE.
- Requests are never accepted in DONE, even when out_ready=1 in that cycle.
- A requester that drops req_valid before the grant loses nothing; no state is kept for it.
- out_q and out_id hold stable while out_valid=1.

## Timing
- Reset values: state=IDLE, ptr=NUM_REQ-1 (requester 0 has first priority), req_ready=0, out_valid=0, out_q=4'h0, out_id=0, busy=0, operand and partial registers 0.
- Latency: out_valid rises 4 cycles after the acceptance edge.
- Throughput: one product per 5 cycles when out_ready is held high.
- Back-pressure: DONE holds indefinitely while out_ready=0.
- Simultaneous requests: exactly one grant; the others keep req_valid high and are served in rotation. No requester waits more than NUM_REQ-1 grants.
- ptr wrap-around: after index NUM_REQ-1 the search continues at 0.
- rst_n assertion mid-operation: immediate return to reset values. The in-flight product is discarded and never presented.

## Configuration
- GF4_MUL_SEQ_ZERO_SKIP_EN:
  - Defined: if the accepted A==0 or B==0, the FSM goes IDLE→DONE with out_q=4'h0, and out_valid rises 1 cycle after acceptance.
  - Undefined: every operation takes the full PH/PL/MID path. The result is the same, only slower.

## Structure
- Shared package gf_pkg holds:
  - the state enum;
  - constants GF4_ONE=4'hF and GF2_ONE=2'b11;
  - mul2 and scl as functions for the testbench reference model.
- One sub-module, gf2_mul_unit: inputs x[1:0], y[1:0], scale; output r[1:0]. It is purely combinational and is the only GF(2^2) multiplier instance in the block.
- Operand-half and scale selection for gf2_mul_unit is driven from the FSM state.

## Test plan
- Single requester 0, A=4'h3, B=4'h3 → req_ready[0] high in the accept cycle; out_q=4'h9 and out_id=0 with out_valid 4 cycles later.
- Identity and commutativity: all 16 A values × B=4'hF, both operand orders → out_q=A each time. Compare against the gf_pkg model for all 256 pairs.
- NUM_REQ=2, both req_valid held high from reset → grants alternate 0,1,0,1; out_id follows the same order.
- out_ready=0 for 10 cycles in DONE → out_valid, out_q and out_id stay stable; req_ready stays 0; busy=1.
- rst_n pulsed low during PL → all outputs return to reset values at once, and no out_valid appears for the aborted operation.
- A=4'h0, B=4'h7:
  - with GF4_MUL_SEQ_ZERO_SKIP_EN, out_valid 1 cycle after accept;
  - without it, 4 cycles after accept;
  - out_q=4'h0 in both builds.

Source files
------------

// File: rtl/gf_pkg.sv
// Shared definitions for the sequential GF(2^4) multiplier: FSM state
// encoding, field constants and the GF(2^2) primitives (mul2, scl).
package gf_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_PH   = 3'd1,
      ST_PL   = 3'd2,
      ST_MID  = 3'd3,
      ST_DONE = 3'd4
   } gf_state_e;

   // Multiplicative identities in the normal bases used here.
   localparam logic [3:0] GF4_ONE = 4'hF;
   localparam logic [1:0] GF2_ONE = 2'b11;

   // GF(2^2) multiply in normal basis [Omega^2, Omega].
   function automatic logic [1:0] mul2(input logic [1:0] x, input logic [1:0] y);
      logic e;
      e = (x[1] ^ x[0]) & (y[1] ^ y[0]);
      return {(x[1] & y[1]) ^ e, (x[0] & y[0]) ^ e};
   endfunction

   // Scale a GF(2^2) element by N.
   function automatic logic [1:0] scl(input logic [1:0] x);
      return {x[0], x[1] ^ x[0]};
   endfunction

endpackage

// File: rtl/gf2_mul_unit.sv
// Combinational GF(2^2) multiplier with optional scale-by-N on the result.
// This is the single multiplier shared across all phases of gf4_mul_seq.
module gf2_mul_unit
   import gf_pkg::*;
(
   input  logic [1:0] x,
   input  logic [1:0] y,
   input  logic       scale,
   output logic [1:0] r
);

   logic [1:0] prod;

   // Product, then optionally scaled for the middle term.
   always_comb begin
      prod = mul2(x, y);
      r    = scale ? scl(prod) : prod;
   end

endmodule

// File: rtl/gf4_mul_seq.sv
// Shared multi-cycle GF(2^4) multiplier with round-robin arbitration.
// One GF(2^2) unit is reused over three phases (high, low, scaled middle).
// Optional build macro GF4_MUL_SEQ_ZERO_SKIP_EN: when defined, an accepted
// operation with a zero operand jumps straight from IDLE to DONE with 0.
//
// Handshakes: a request transfers on a rising edge where req_valid[i] and
// req_ready[i] are both high; req_ready is only ever asserted in IDLE and
// for one requester at a time. A result transfers on a rising edge where
// out_valid and out_ready are both high; out_q/out_id stay stable until then.
module gf4_mul_seq
   import gf_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int ID_W    = $clog2(NUM_REQ)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NUM_REQ-1:0]   req_valid,
   input  logic [4*NUM_REQ-1:0] req_a,
   input  logic [4*NUM_REQ-1:0] req_b,
   output logic [NUM_REQ-1:0]   req_ready,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [3:0]           out_q,
   output logic [ID_W-1:0]      out_id,
   output logic                 busy
);

   // Requester 0 gets first priority out of reset.
   localparam logic [ID_W-1:0] PTR_RST = ID_W'(NUM_REQ - 1);

   gf_state_e       state_q, state_d;
   logic [ID_W-1:0] ptr_q;
   logic [ID_W-1:0] id_q;
   logic [ID_W-1:0] out_id_q;
   logic [3:0]      a_q, b_q;
   logic [3:0]      out_q_q;
   logic [1:0]      ph_q, pl_q;

   logic [ID_W-1:0] grant_idx;
   logic            grant_found;
   logic [3:0]      sel_a, sel_b;
   int unsigned     cand;

   logic [1:0]      unit_x, unit_y, unit_r;
   logic            unit_scale;

   // Round-robin search starting just after the last granted index.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      cand        = 0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         cand = (int'(ptr_q) + k) % NUM_REQ;
         if (!grant_found && req_valid[cand[ID_W-1:0]]) begin
            grant_found = 1'b1;
            grant_idx   = cand[ID_W-1:0];
         end
      end
   end

   // Operand mux for the winning requester.
   always_comb begin
      sel_a = '0;
      sel_b = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (grant_idx == k[ID_W-1:0]) begin
            sel_a = req_a[4*k +: 4];
            sel_b = req_b[4*k +: 4];
         end
      end
   end

   // One-hot acceptance, only while idle.
   always_comb begin
      req_ready = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         req_ready[k] = (state_q == ST_IDLE) && grant_found &&
                        (grant_idx == k[ID_W-1:0]);
      end
   end

   // State-driven selection of operand halves and scaling for the shared unit.
   always_comb begin
      unit_x     = '0;
      unit_y     = '0;
      unit_scale = 1'b0;
      case (state_q)
         ST_PH: begin
            unit_x = a_q[3:2];
            unit_y = b_q[3:2];
         end
         ST_PL: begin
            unit_x = a_q[1:0];
            unit_y = b_q[1:0];
         end
         ST_MID: begin
            unit_x     = a_q[3:2] ^ a_q[1:0];
            unit_y     = b_q[3:2] ^ b_q[1:0];
            unit_scale = 1'b1;
         end
         default: ;
      endcase
   end

   gf2_mul_unit u_mul (
      .x     (unit_x),
      .y     (unit_y),
      .scale (unit_scale),
      .r     (unit_r)
   );

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (grant_found) begin
`ifdef GF4_MUL_SEQ_ZERO_SKIP_EN
               state_d = (sel_a == 4'h0 || sel_b == 4'h0) ? ST_DONE : ST_PH;
`else
               state_d = ST_PH;
`endif
            end
         end
         ST_PH:   state_d = ST_PL;
         ST_PL:   state_d = ST_MID;
         ST_MID:  state_d = ST_DONE;
         ST_DONE: if (out_ready) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   // Operand capture, partial products and registered result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q    <= PTR_RST;
         id_q     <= '0;
         a_q      <= '0;
         b_q      <= '0;
         ph_q     <= '0;
         pl_q     <= '0;
         out_q_q  <= '0;
         out_id_q <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (grant_found) begin
                  a_q   <= sel_a;
                  b_q   <= sel_b;
                  id_q  <= grant_idx;
                  ptr_q <= grant_idx;
`ifdef GF4_MUL_SEQ_ZERO_SKIP_EN
                  if (state_d == ST_DONE) begin
                     out_q_q  <= 4'h0;
                     out_id_q <= grant_idx;
                  end
`endif
               end
            end
            ST_PH:  ph_q <= unit_r;
            ST_PL:  pl_q <= unit_r;
            ST_MID: begin
               out_q_q  <= {ph_q ^ unit_r, pl_q ^ unit_r};
               out_id_q <= id_q;
            end
            default: ;
         endcase
      end
   end

   assign out_valid = (state_q == ST_DONE);
   assign busy      = (state_q != ST_IDLE);
   assign out_q     = out_q_q;
   assign out_id    = out_id_q;

endmodule

// File: tb/tb_gf4_mul_seq.sv
// Self-checking bench for gf4_mul_seq (NUM_REQ=2) with a behavioural model.
module tb_gf4_mul_seq;
   import gf_pkg::*;

   localparam int NUM_REQ = 2;
   localparam int ID_W    = $clog2(NUM_REQ);

   logic                 clk;
   logic                 rst_n;
   logic [NUM_REQ-1:0]   req_valid;
   logic [4*NUM_REQ-1:0] req_a;
   logic [4*NUM_REQ-1:0] req_b;
   logic [NUM_REQ-1:0]   req_ready;
   logic                 out_valid;
   logic                 out_ready;
   logic [3:0]           out_q;
   logic [ID_W-1:0]      out_id;
   logic                 busy;

   int n_pass;
   int n_total;

   gf4_mul_seq #(.NUM_REQ(NUM_REQ)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_ready (req_ready),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_q     (out_q),
      .out_id    (out_id),
      .busy      (busy)
   );

   // Clock and watchdog.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Reference: GF(2^4) product composed from the half-field rules.
   function automatic logic [3:0] ref_mul(input logic [3:0] a, input logic [3:0] b);
      logic [1:0] ph, pl, em;
      ph = mul2(a[3:2], b[3:2]);
      pl = mul2(a[1:0], b[1:0]);
      em = scl(mul2(a[3:2] ^ a[1:0], b[3:2] ^ b[1:0]));
      return {ph ^ em, pl ^ em};
   endfunction

   function automatic int exp_lat(input logic [3:0] a, input logic [3:0] b);
`ifdef GF4_MUL_SEQ_ZERO_SKIP_EN
      if (a == 4'h0 || b == 4'h0) return 1;
`endif
      return 4;
   endfunction

   task automatic apply_reset();
      rst_n     = 1'b0;
      req_valid = '0;
      req_a     = '0;
      req_b     = '0;
      out_ready = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Driver: one operation from requester rq with out_ready held high.
   task automatic run_op(input int rq, input logic [3:0] a, input logic [3:0] b,
                         output int lat, output logic [3:0] q,
                         output logic [ID_W-1:0] id, output bit ok);
      int guard;
      ok  = 1'b0;
      lat = -1;
      q   = 'x;
      id  = 'x;
      req_valid         = '0;
      req_valid[rq]     = 1'b1;
      req_a[4*rq +: 4]  = a;
      req_b[4*rq +: 4]  = b;
      out_ready         = 1'b1;
      #1;
      guard = 0;
      while (!req_ready[rq] && guard < 40) begin
         @(negedge clk); #1; guard++;
      end
      if (!req_ready[rq]) begin
         req_valid = '0;
         return;
      end
      @(negedge clk);
      req_valid[rq] = 1'b0;
      lat = 1;
      #1;
      while (!out_valid && lat < 40) begin
         @(negedge clk); #1; lat++;
      end
      if (out_valid) begin
         ok = 1'b1;
         q  = out_q;
         id = out_id;
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      apply_reset();
      #1;
      n_total++; if (req_ready !== '0) $display("FAIL reset_req_ready: got %b want 0", req_ready); else n_pass++;
      n_total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else n_pass++;
      n_total++; if (out_q !== 4'h0) $display("FAIL reset_out_q: got %h want 0", out_q); else n_pass++;
      n_total++; if (out_id !== '0) $display("FAIL reset_out_id: got %0d want 0", out_id); else n_pass++;
      n_total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
   endtask

   task automatic test_basic();
      int lat; logic [3:0] q; logic [ID_W-1:0] id; bit ok;
      run_op(0, 4'h3, 4'h3, lat, q, id, ok);
      n_total++;
      if (!ok) $display("FAIL basic_handshake: no accept or no result within bound");
      else begin
         n_pass++;
         n_total++; if (lat !== 4) $display("FAIL basic_latency: got %0d want 4", lat); else n_pass++;
         n_total++; if (q !== 4'h9) $display("FAIL basic_q: got %h want 9", q); else n_pass++;
         n_total++; if (id !== '0) $display("FAIL basic_id: got %0d want 0", id); else n_pass++;
      end
   endtask

   task automatic test_identity();
      int lat; logic [3:0] q; logic [ID_W-1:0] id; bit ok;
      for (int a = 0; a < 16; a++) begin
         for (int ord = 0; ord < 2; ord++) begin
            if (ord == 0) run_op(a % NUM_REQ, 4'(a), GF4_ONE, lat, q, id, ok);
            else          run_op((a + 1) % NUM_REQ, GF4_ONE, 4'(a), lat, q, id, ok);
            n_total++;
            if (!ok || q !== 4'(a))
               $display("FAIL identity a=%h ord=%0d: got %h (ok=%0d) want %h", a, ord, q, ok, a);
            else n_pass++;
         end
      end
   endtask

   task automatic test_sweep();
      int lat; logic [3:0] q; logic [ID_W-1:0] id; bit ok; int rq;
      for (int a = 0; a < 16; a++) begin
         for (int b = 0; b < 16; b++) begin
            rq = $urandom_range(0, NUM_REQ - 1);
            run_op(rq, 4'(a), 4'(b), lat, q, id, ok);
            n_total++;
            if (!ok) begin
               $display("FAIL sweep_handshake a=%h b=%h: timed out", a, b);
               continue;
            end
            n_pass++;
            n_total++;
            if (q !== ref_mul(4'(a), 4'(b)))
               $display("FAIL sweep_q a=%h b=%h: got %h want %h", a, b, q, ref_mul(4'(a), 4'(b)));
            else n_pass++;
            n_total++;
            if (id !== ID_W'(rq)) $display("FAIL sweep_id a=%h b=%h: got %0d want %0d", a, b, id, rq);
            else n_pass++;
            n_total++;
            if (lat !== exp_lat(4'(a), 4'(b)))
               $display("FAIL sweep_latency a=%h b=%h: got %0d want %0d", a, b, lat, exp_lat(4'(a), 4'(b)));
            else n_pass++;
         end
      end
   endtask

   task automatic test_back_to_back();
      int guard, model_ptr, exp_id, last_grant, cyc;
      logic [3:0] opa [NUM_REQ];
      logic [3:0] opb [NUM_REQ];
      logic [NUM_REQ-1:0] exp_rdy;
      rst_n = 1'b0;
      out_ready = 1'b1;
      for (int r = 0; r < NUM_REQ; r++) begin
         opa[r] = 4'($urandom_range(1, 15));
         opb[r] = 4'($urandom_range(1, 15));
         req_a[4*r +: 4] = opa[r];
         req_b[4*r +: 4] = opb[r];
      end
      req_valid = '1;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1;
      model_ptr  = NUM_REQ - 1;
      last_grant = -1;
      cyc        = 0;
      for (int n = 0; n < 6; n++) begin
         guard = 0;
         while (req_ready == '0 && guard < 20) begin
            @(negedge clk); #1; guard++; cyc++;
         end
         exp_id  = (model_ptr + 1) % NUM_REQ;
         exp_rdy = '0;
         exp_rdy[exp_id] = 1'b1;
         n_total++;
         if (req_ready !== exp_rdy) $display("FAIL b2b_grant n=%0d: got %b want %b", n, req_ready, exp_rdy);
         else n_pass++;
         if (last_grant >= 0) begin
            n_total++;
            if (cyc - last_grant !== 5) $display("FAIL b2b_interval n=%0d: got %0d want 5", n, cyc - last_grant);
            else n_pass++;
         end
         last_grant = cyc;
         model_ptr  = exp_id;
         guard = 0;
         @(negedge clk); #1; cyc++;
         while (!out_valid && guard < 20) begin
            @(negedge clk); #1; guard++; cyc++;
         end
         n_total++;
         if (!out_valid || out_id !== ID_W'(exp_id) || out_q !== ref_mul(opa[exp_id], opb[exp_id]))
            $display("FAIL b2b_result n=%0d: got v=%b id=%0d q=%h want v=1 id=%0d q=%h",
                     n, out_valid, out_id, out_q, exp_id, ref_mul(opa[exp_id], opb[exp_id]));
         else n_pass++;
         opa[exp_id] = 4'($urandom_range(1, 15));
         opb[exp_id] = 4'($urandom_range(1, 15));
         req_a[4*exp_id +: 4] = opa[exp_id];
         req_b[4*exp_id +: 4] = opb[exp_id];
         @(negedge clk); #1; cyc++;
      end
      req_valid = '0;
      @(negedge clk);
   endtask

   task automatic test_backpressure();
      int guard;
      logic [3:0] a, b, exp_q;
      a = 4'($urandom_range(1, 15));
      b = 4'($urandom_range(1, 15));
      exp_q = ref_mul(a, b);
      out_ready = 1'b0;
      req_a[7:4] = a;
      req_b[7:4] = b;
      req_valid  = 2'b10;
      #1;
      guard = 0;
      while (!req_ready[1] && guard < 20) begin @(negedge clk); #1; guard++; end
      @(negedge clk);
      req_valid = 2'b11;
      #1;
      guard = 0;
      while (!out_valid && guard < 20) begin @(negedge clk); #1; guard++; end
      n_total++;
      if (!out_valid) $display("FAIL bp_reach_done: out_valid never rose");
      else n_pass++;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk); #1;
         n_total++;
         if (out_valid !== 1'b1 || out_q !== exp_q || out_id !== 1'b1 || req_ready !== '0 || busy !== 1'b1)
            $display("FAIL bp_hold c=%0d: got v=%b q=%h id=%0d rdy=%b busy=%b want v=1 q=%h id=1 rdy=0 busy=1",
                     c, out_valid, out_q, out_id, req_ready, busy, exp_q);
         else n_pass++;
      end
      req_valid = '0;
      out_ready = 1'b1;
      @(negedge clk); #1;
      n_total++;
      if (out_valid !== 1'b0 || busy !== 1'b0)
         $display("FAIL bp_release: got v=%b busy=%b want 0 0", out_valid, busy);
      else n_pass++;
   endtask

   task automatic test_reset_midop();
      int lat, guard; logic [3:0] q; logic [ID_W-1:0] id; bit ok, seen;
      run_op(1, 4'h3, 4'h3, lat, q, id, ok);
      n_total++;
      if (!ok || q !== 4'h9 || id !== 1'b1) $display("FAIL rst_prior_op: got q=%h id=%0d ok=%0d want 9 1 1", q, id, ok);
      else n_pass++;
      req_a[3:0] = 4'h3;
      req_b[3:0] = 4'h5;
      req_valid  = 2'b01;
      #1;
      guard = 0;
      while (!req_ready[0] && guard < 20) begin @(negedge clk); #1; guard++; end
      @(negedge clk);
      req_valid = '0;
      @(negedge clk); #1;
      rst_n = 1'b0;
      #1;
      n_total++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || req_ready !== '0 || out_q !== 4'h0 || out_id !== '0)
         $display("FAIL rst_midop_outputs: got v=%b busy=%b rdy=%b q=%h id=%0d want all 0",
                  out_valid, busy, req_ready, out_q, out_id);
      else n_pass++;
      @(negedge clk);
      rst_n = 1'b1;
      seen = 1'b0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk); #1;
         if (out_valid) seen = 1'b1;
      end
      n_total++;
      if (seen !== 1'b0) $display("FAIL rst_midop_no_result: got out_valid after abort want none");
      else n_pass++;
   endtask

   task automatic test_zero();
      int lat; logic [3:0] q; logic [ID_W-1:0] id; bit ok;
      run_op(0, 4'h0, 4'h7, lat, q, id, ok);
      n_total++;
      if (!ok) $display("FAIL zero_handshake: timed out");
      else begin
         n_pass++;
         n_total++;
         if (lat !== exp_lat(4'h0, 4'h7)) $display("FAIL zero_latency: got %0d want %0d", lat, exp_lat(4'h0, 4'h7));
         else n_pass++;
         n_total++;
         if (q !== 4'h0) $display("FAIL zero_q: got %h want 0", q); else n_pass++;
      end
   endtask

   initial begin
      n_pass  = 0;
      n_total = 0;
      test_reset();
      test_basic();
      test_identity();
      test_sweep();
      test_zero();
      test_back_to_back();
      test_backpressure();
      test_reset_midop();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
